// File: rtl/stream_pkt_buf.sv
// AXI-Stream beat FIFO with occupancy/packet counters and registered-state handshakes.
// Define STREAM_PKT_BUF_PACKET_MODE_EN to hold the output until a whole packet is stored.
module stream_pkt_buf #(
  parameter int DEPTH      = 4,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  localparam int CW = $clog2(DEPTH+1),
  localparam int SW = DATA_WIDTH/8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_t_valid,
  output logic                  in_t_ready,
  input  logic [ID_WIDTH-1:0]   in_t_id,
  input  logic [DEST_WIDTH-1:0] in_t_dest,
  input  logic [DATA_WIDTH-1:0] in_t_data,
  input  logic [SW-1:0]         in_t_strb,
  input  logic [SW-1:0]         in_t_keep,
  input  logic                  in_t_last,
  input  logic [USER_WIDTH-1:0] in_t_user,
  output logic                  out_t_valid,
  input  logic                  out_t_ready,
  output logic [ID_WIDTH-1:0]   out_t_id,
  output logic [DEST_WIDTH-1:0] out_t_dest,
  output logic [DATA_WIDTH-1:0] out_t_data,
  output logic [SW-1:0]         out_t_strb,
  output logic [SW-1:0]         out_t_keep,
  output logic                  out_t_last,
  output logic [USER_WIDTH-1:0] out_t_user,
  output logic [CW-1:0]         occupancy,
  output logic [CW-1:0]         pkt_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_P = PW'(DEPTH-1);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DEST_WIDTH-1:0] dest;
    logic [DATA_WIDTH-1:0] data;
    logic [SW-1:0]         strb;
    logic [SW-1:0]         keep;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
  } beat_t;

  beat_t         mem [DEPTH];
  beat_t         head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;

  assign in_t_ready = (occupancy < FULL_C);
`ifdef STREAM_PKT_BUF_PACKET_MODE_EN
  // Full override lets packets longer than DEPTH stream through instead of deadlocking.
  assign out_t_valid = (occupancy != '0) && ((pkt_count != '0) || (occupancy == FULL_C));
`else
  assign out_t_valid = (occupancy != '0);
`endif

  assign push = in_t_valid && in_t_ready;
  assign pop  = out_t_valid && out_t_ready;
  assign head = mem[rd_ptr];

  assign out_t_id   = head.id;
  assign out_t_dest = head.dest;
  assign out_t_data = head.data;
  assign out_t_strb = head.strb;
  assign out_t_keep = head.keep;
  assign out_t_last = head.last;
  assign out_t_user = head.user;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{in_t_id, in_t_dest, in_t_data, in_t_strb, in_t_keep, in_t_last, in_t_user};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      pkt_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_P) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      occupancy <= occupancy + 1'b1;
      else if (pop && !push) occupancy <= occupancy - 1'b1;
      if ((push && in_t_last) && !(pop && out_t_last))      pkt_count <= pkt_count + 1'b1;
      else if ((pop && out_t_last) && !(push && in_t_last)) pkt_count <= pkt_count - 1'b1;
    end
  end
endmodule

// File: tb/tb_stream_pkt_buf.sv
// Scoreboard bench for stream_pkt_buf (DEPTH=4); packet-mode cases run when the macro is defined.
module tb_stream_pkt_buf;
  localparam int CW = 3;

  typedef struct packed {
    logic       id;
    logic       dest;
    logic [31:0] data;
    logic [3:0] strb;
    logic [3:0] keep;
    logic       last;
    logic       user;
  } beat_t;

  logic clk = 0, rst = 1;
  logic in_t_valid = 0, in_t_ready, out_t_valid, out_t_ready = 0;
  beat_t in_b = '0, out_b;
  logic [CW-1:0] occupancy, pkt_count;

  int n_chk = 0, n_fail = 0, n_pop = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  stream_pkt_buf #(.DEPTH(4), .ID_WIDTH(1), .DEST_WIDTH(1), .DATA_WIDTH(32), .USER_WIDTH(1)) dut (
    .clk(clk), .rst(rst),
    .in_t_valid(in_t_valid), .in_t_ready(in_t_ready),
    .in_t_id(in_b.id), .in_t_dest(in_b.dest), .in_t_data(in_b.data),
    .in_t_strb(in_b.strb), .in_t_keep(in_b.keep), .in_t_last(in_b.last), .in_t_user(in_b.user),
    .out_t_valid(out_t_valid), .out_t_ready(out_t_ready),
    .out_t_id(out_b.id), .out_t_dest(out_b.dest), .out_t_data(out_b.data),
    .out_t_strb(out_b.strb), .out_t_keep(out_b.keep), .out_t_last(out_b.last), .out_t_user(out_b.user),
    .occupancy(occupancy), .pkt_count(pkt_count)
  );

  function automatic beat_t mk(input logic [31:0] d, input logic l);
    beat_t b;
    b.id = d[0]; b.dest = d[1]; b.user = d[2]; b.data = d;
    b.strb = ~d[3:0]; b.keep = d[7:4] ^ 4'h5; b.last = l;
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at the negedge completes at the next posedge.
  always @(negedge clk) begin
    if (!rst && out_t_valid && out_t_ready) begin
      n_chk++;
      n_pop++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got data %0h expected none", out_b.data);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        if (out_b !== e) begin
          n_fail++;
          $display("FAIL beat: got %0h expected %0h", out_b, e);
        end
      end
    end
  end

  task automatic push(input logic [31:0] d, input logic l);
    int t;
    in_b = mk(d, l);
    in_t_valid = 1;
    t = 0;
    @(negedge clk);
    while (!in_t_ready && t < 200) begin @(negedge clk); t++; end
    if (!in_t_ready) check("push_timeout", 0, 1);
    else exp_q.push_back(in_b);
    @(posedge clk); #1;
    in_t_valid = 0;
  endtask

  task automatic drain(input string name);
    int t;
    out_t_ready = 1;
    t = 0;
    while ((exp_q.size() != 0 || occupancy != 0) && t < 200) begin @(posedge clk); #1; t++; end
    check({name, "_drained_occ"}, 64'(occupancy), 0);
    check({name, "_drained_q"}, 64'(exp_q.size()), 0);
    out_t_ready = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_in_ready", 64'(in_t_ready), 1);
      check("rst_out_valid", 64'(out_t_valid), 0);
      check("rst_occ", 64'(occupancy), 0);
      check("rst_pkt", 64'(pkt_count), 0);
    end
    @(posedge clk); #1;

`ifndef STREAM_PKT_BUF_PACKET_MODE_EN
    // Fill with downstream stalled, then release and watch 1 beat/cycle.
    for (int i = 0; i < 4; i++) push(32'(i), 1'b0);
    check("full_in_ready", 64'(in_t_ready), 0);
    check("full_occ", 64'(occupancy), 4);
    fork
      begin push(32'd4, 1'b0); push(32'd5, 1'b1); end
    join_none
    out_t_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("ct_out_valid", 64'(out_t_valid), 1);
      if (i == 0) check("ct_ready_during_pop", 64'(in_t_ready), 0);
      if (i == 1) check("ct_ready_after_pop", 64'(in_t_ready), 1);
    end
    @(negedge clk);
    check("ct_empty_valid", 64'(out_t_valid), 0);
    check("ct_empty_occ", 64'(occupancy), 0);
    check("ct_pops", 64'(n_pop), 6);
    @(posedge clk); #1;
    out_t_ready = 0;
`else
    // Three-beat packet with downstream ready: held until last beat stored.
    out_t_ready = 1;
    fork
      begin push(32'h10, 1'b0); push(32'h11, 1'b0); push(32'h12, 1'b1); end
    join_none
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("pkt3_valid", 64'(out_t_valid), (i >= 3 && i <= 5) ? 1 : 0);
      if (i == 2) check("pkt3_cnt0", 64'(pkt_count), 0);
      if (i == 3) check("pkt3_cnt1", 64'(pkt_count), 1);
      if (i == 6) check("pkt3_cnt_end", 64'(pkt_count), 0);
    end
    check("pkt3_pops", 64'(n_pop), 3);
    @(posedge clk); #1;
    // Six-beat packet longer than DEPTH: released once full.
    fork
      begin for (int i = 0; i < 6; i++) push(32'h20 + 32'(i), (i == 5)); end
    join_none
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("pkt6_valid", 64'(out_t_valid), (i == 4) ? 1 : 0);
      if (i == 4) check("pkt6_occ_full", 64'(occupancy), 4);
    end
    @(posedge clk); #1;
    drain("pkt6");
    check("pkt6_pops", 64'(n_pop), 9);
    check("pkt6_cnt", 64'(pkt_count), 0);
`endif

    // Simultaneous push and pop, both carrying last, at occupancy 2.
    out_t_ready = 0;
    push(32'h31, 1'b1);
    push(32'h32, 1'b1);
    check("sim_pre_occ", 64'(occupancy), 2);
    check("sim_pre_pkt", 64'(pkt_count), 2);
    in_b = mk(32'h33, 1'b1);
    in_t_valid = 1;
    out_t_ready = 1;
    exp_q.push_back(in_b);
    @(posedge clk); #1;
    in_t_valid = 0;
    out_t_ready = 0;
    @(negedge clk);
    check("sim_occ", 64'(occupancy), 2);
    check("sim_pkt", 64'(pkt_count), 2);
    @(posedge clk); #1;
    drain("sim");

    // Reset mid-packet discards everything.
    push(32'h41, 1'b0); push(32'h42, 1'b0); push(32'h43, 1'b0);
    check("mid_occ", 64'(occupancy), 3);
    rst = 1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("mid_rst_occ", 64'(occupancy), 0);
    check("mid_rst_pkt", 64'(pkt_count), 0);
    check("mid_rst_valid", 64'(out_t_valid), 0);
    @(posedge clk); #1;
    n_pop = 0;
    out_t_ready = 1;
    push(32'hA5, 1'b1);
    drain("post_rst");
    check("post_rst_pops", 64'(n_pop), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_pkt_buf.md
# stream_pkt_buf

Parametrised AXI-Stream FIFO buffer with occupancy reporting and an optional store-and-forward (packet) mode. It sits between any two AXI-Stream stages, carries the full sideband (id, dest, data, strb, keep, last, user) and breaks all combinational paths between its two sides. In packet mode the output presents a packet only once its last beat is stored, so downstream consumers never stall mid-packet.

## Interface
- DEPTH, 4, number of beat entries; ≥2, need not be a power of two
- ID_WIDTH, 1, t_id width, ≥1
- DEST_WIDTH, 1, t_dest width, ≥1
- DATA_WIDTH, 32, t_data width; multiple of 8
- USER_WIDTH, 1, t_user width, ≥1
- CW is $clog2(DEPTH+1); SW is DATA_WIDTH/8
- clk  in  1  clock; everything is sampled on its rising edge
- rst  in  1  synchronous reset, active-high
- in_t_valid / in_t_ready  in / out  1 / 1  upstream handshake
- in_t_id, in_t_dest, in_t_data  in  ID_WIDTH, DEST_WIDTH, DATA_WIDTH  beat payload
- in_t_strb, in_t_keep  in  SW each  byte qualifiers
- in_t_last, in_t_user  in  1, USER_WIDTH  end-of-packet and user sideband
- out_t_valid / out_t_ready  out / in  1 / 1  downstream handshake
- out_t_id … out_t_user  out  same widths as the in_t_* fields  head beat payload
- occupancy  out  CW  beats currently stored
- pkt_count  out  CW  complete packets currently stored (beats with t_last)

## Operation
- Storage: DEPTH-entry register array. Write pointer and read pointer each wrap from DEPTH-1 to 0. Occupancy counter: +1 on push only, −1 on pop only, unchanged on both or neither.
- Push when in_t_valid && in_t_ready. in_t_ready is 1 exactly when occupancy < DEPTH; it depends only on registered state.
- Pop when out_t_valid && out_t_ready. out_t_* show the entry at the read pointer and are held stable while out_t_valid is 1 and out_t_ready is 0.
- pkt_count: +1 on a push with in_t_last=1, −1 on a pop with out_t_last=1, unchanged when both happen together. It is always maintained, in both modes.
- Cut-through, when the macro is undefined: out_t_valid is occupancy != 0.
- Store-and-forward, when the macro is defined: out_t_valid is (occupancy != 0) && (pkt_count != 0 || occupancy == DEPTH).
  - The full-override prevents deadlock on packets longer than DEPTH. Such a packet streams out in cut-through fashion once the buffer fills.
- Payload passes through bit-exact. No field is interpreted except t_last.
- Reset mid-operation discards all stored beats, including any partial packet. No beat is emitted after reset until a new push.

## Timing
- Reset values: in_t_ready=1, out_t_valid=0, occupancy=0, pkt_count=0. out_t_* payload is don't-care while out_t_valid=0.
- Latency: a beat pushed in cycle N can be popped in cycle N+1 at the earliest. There is no same-cycle bypass.
- In packet mode, the first beat of a packet becomes valid in the cycle after its t_last beat is pushed, or in the cycle after the buffer fills.
- Full and popping: in_t_ready stays 0 in that cycle and rises the next cycle. There is no combinational out_t_ready→in_t_ready path.
- Empty and pushing: out_t_valid rises the next cycle, subject to the packet-mode rule.
- Sustained throughput is 1 beat/cycle whenever occupancy is between 1 and DEPTH-1 and both sides are ready.
- occupancy and pkt_count are registered and reflect all pushes and pops up to the previous edge.

## Configuration
- STREAM_PKT_BUF_PACKET_MODE_EN
  - Defined: store-and-forward gating of out_t_valid, as described above.
  - Undefined: plain cut-through FIFO. pkt_count is still output, but it does not gate the output.

## Test plan
- Reset, then idle: in_t_ready=1, out_t_valid=0, occupancy=0, pkt_count=0 → all hold for 10 cycles.
- Cut-through build, DEPTH=4: push 6 beats, data 0..5, with out_t_ready=0 → in_t_ready falls after the 4th push and occupancy=4. Then raise out_t_ready → data 0..5 emerge in order, one per cycle after the first, with in_t_ready rising one cycle after the first pop.
- Packet build: push a 3-beat packet with last on beat 3 while out_t_ready=1 → out_t_valid stays 0 until the cycle after beat 3. Beats then arrive back-to-back, and pkt_count goes 0→1→0.
- Packet build, DEPTH=4: push a 6-beat packet → out_t_valid rises the cycle after occupancy reaches 4. All 6 beats are delivered intact and the last beat carries t_last=1.
- Simultaneous push and pop at occupancy=2, with the pushed beat last=1 and the popped beat last=1 → occupancy stays 2 and pkt_count is unchanged.
- Assert rst mid-packet at occupancy=3 → next cycle occupancy=0, pkt_count=0, out_t_valid=0. A following 1-beat packet with data 0xA5 emerges correctly.
